// File: rtl/spi_master.sv
// SPI master for the SPI slave + RAM subsystem: frames 10-bit commands onto MOSI
// under SS_n and captures the 8-bit read-data reply from MISO, LSB first.
module spi_master #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned GAP     = 3
) (
  input  logic       clk,
  input  logic       a_rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] payload,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SHIFT,
    S_WAIT,
    S_RECV,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam logic [3:0] SHIFT_LAST  = 4'd9;
  localparam logic [3:0] RECV_LAST   = 4'd7;
  localparam logic [3:0] RD_LAST     = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] tx_q, tx_d;
  logic       is_read_q, is_read_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    is_read_d  = is_read_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    ss_n_d     = ss_n_q;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    mosi_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SELECT;
          tx_d      = {cmd, payload};
          is_read_d = (cmd == CMD_RD_DATA);
          busy_d    = 1'b1;
          ss_n_d    = 1'b0;
        end
      end

      // MOSI is registered, so bit 9 is launched here to appear in the first SHIFT cycle.
      S_SELECT: begin
        state_d = S_SHIFT;
        cnt_d   = 4'd0;
        mosi_d  = tx_q[9];
        tx_d    = {tx_q[8:0], 1'b0};
      end

      S_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = 4'd0;
          state_d = is_read_q ? S_WAIT : S_HOLD;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          mosi_d = tx_q[9];
          tx_d   = {tx_q[8:0], 1'b0};
        end
      end

      S_WAIT: begin
        if (cnt_q == RD_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_RECV: begin
        rx_shift_d = {MISO, rx_shift_q[7:1]};
        if (cnt_q == RECV_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_HOLD: begin
        state_d = S_GAP;
        cnt_d   = 4'd0;
        ss_n_d  = 1'b1;
        done_d  = 1'b1;
        if (is_read_q) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      tx_q       <= 10'd0;
      is_read_q  <= 1'b0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      is_read_q  <= is_read_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (RD_WAIT=2 and 3), each against a behavioural
// SPI slave + RAM; a scoreboard compares every completed frame with its expectation.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       a_rst_n;
  logic       start_i   [2];
  logic [1:0] cmd_i     [2];
  logic [7:0] payload_i [2];
  logic       busy_o    [2];
  logic       done_o    [2];
  logic [7:0] rx_data_o [2];
  logic       rx_valid_o[2];
  logic       ss_n_o    [2];
  logic       mosi_o    [2];
  logic       miso_i    [2];

  always #5 clk = ~clk;

  spi_master #(.RD_WAIT(2), .GAP(3)) u_dut0 (
    .clk(clk), .a_rst_n(a_rst_n), .start(start_i[0]), .cmd(cmd_i[0]),
    .payload(payload_i[0]), .busy(busy_o[0]), .done(done_o[0]),
    .rx_data(rx_data_o[0]), .rx_valid(rx_valid_o[0]), .SS_n(ss_n_o[0]),
    .MOSI(mosi_o[0]), .MISO(miso_i[0])
  );

  spi_master #(.RD_WAIT(3), .GAP(3)) u_dut1 (
    .clk(clk), .a_rst_n(a_rst_n), .start(start_i[1]), .cmd(cmd_i[1]),
    .payload(payload_i[1]), .busy(busy_o[1]), .done(done_o[1]),
    .rx_data(rx_data_o[1]), .rx_valid(rx_valid_o[1]), .SS_n(ss_n_o[1]),
    .MOSI(mosi_o[1]), .MISO(miso_i[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  typedef struct {
    logic [9:0] frame;
    logic       is_read;
    logic [7:0] rx;
    int         ss_len;
    int         busy_len;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic push(input int k, input logic [9:0] frame, input logic is_read,
                      input logic [7:0] rx, input int ss_len, input int busy_len);
    exp_t e;
    e.frame = frame; e.is_read = is_read; e.rx = rx;
    e.ss_len = ss_len; e.busy_len = busy_len;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t pop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Behavioural slave + RAM: frame index 0 is the select cycle, 1..10 the command bits.
  int         slv_wait[2];
  int         s_cnt   [2];
  logic [9:0] s_sh    [2];
  logic [7:0] s_waddr [2];
  logic [7:0] s_raddr [2];
  logic [7:0] ram     [2][256];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!a_rst_n) begin
        s_cnt[k] = 0; s_sh[k] = '0; s_waddr[k] = '0; s_raddr[k] = '0; miso_i[k] = 1'b0;
        for (int a = 0; a < 256; a++) ram[k][a] = 8'h00;
      end else if (!ss_n_o[k]) begin
        int j;
        if (s_cnt[k] >= 1 && s_cnt[k] <= 10) s_sh[k] = {s_sh[k][8:0], mosi_o[k]};
        j = s_cnt[k] - (11 + slv_wait[k]);
        if (s_cnt[k] >= 11 && s_sh[k][9:8] == 2'b11 && j >= 0 && j < 8)
          miso_i[k] = ram[k][s_raddr[k]][j];
        else
          miso_i[k] = 1'b0;
        s_cnt[k]++;
      end else begin
        if (s_cnt[k] >= 11) begin
          case (s_sh[k][9:8])
            2'b00:   s_waddr[k] = s_sh[k][7:0];
            2'b01:   ram[k][s_waddr[k]] = s_sh[k][7:0];
            2'b10:   s_raddr[k] = s_sh[k][7:0];
            default: ;
          endcase
        end
        s_cnt[k]  = 0;
        miso_i[k] = 1'b0;
      end
    end
  end

  // Monitor: reconstructs each frame from the pins and pops one expectation per done.
  int         low_cnt  [2];
  logic [9:0] mosi_hist[2];
  logic       mosi_bad [2];
  int         busy_cnt [2];
  int         exp_busy [2];
  logic       prev_ss  [2];
  logic       prev_busy[2];
  int         done_seen[2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!a_rst_n) begin
        low_cnt[k] = 0; mosi_hist[k] = '0; mosi_bad[k] = 1'b0;
        busy_cnt[k] = 0; exp_busy[k] = 0; prev_ss[k] = 1'b1; prev_busy[k] = 1'b0;
      end else begin
        if (!ss_n_o[k]) begin
          if (low_cnt[k] >= 1 && low_cnt[k] <= 10) mosi_hist[k] = {mosi_hist[k][8:0], mosi_o[k]};
          else if (mosi_o[k]) mosi_bad[k] = 1'b1;
          low_cnt[k]++;
        end else if (mosi_o[k]) begin
          mosi_bad[k] = 1'b1;
        end

        if (done_o[k]) begin
          done_seen[k]++;
          if (qsize(k) == 0) begin
            fail($sformatf("unexpected_done_dut%0d", k));
          end else begin
            exp_t e;
            e = pop(k);
            check("done_after_ss_rise", {30'd0, prev_ss[k], ss_n_o[k]}, 32'd1);
            check("ss_low_len", low_cnt[k], e.ss_len);
            check("mosi_frame", {22'd0, mosi_hist[k]}, {22'd0, e.frame});
            check("mosi_zero_outside_shift", {31'd0, mosi_bad[k]}, 32'd0);
            check("rx_valid", {31'd0, rx_valid_o[k]}, {31'd0, e.is_read});
            check("rx_data", {24'd0, rx_data_o[k]}, {24'd0, e.rx});
            exp_busy[k] = e.busy_len;
          end
          low_cnt[k] = 0; mosi_hist[k] = '0; mosi_bad[k] = 1'b0;
        end else if (rx_valid_o[k]) begin
          fail($sformatf("rx_valid_without_done_dut%0d", k));
        end

        if (busy_o[k]) busy_cnt[k]++;
        if (prev_busy[k] && !busy_o[k]) begin
          check("busy_len", busy_cnt[k], exp_busy[k]);
          busy_cnt[k] = 0;
          exp_busy[k] = 0;
        end
        prev_ss[k]   = ss_n_o[k];
        prev_busy[k] = busy_o[k];
      end
    end
  end

  task automatic wait_idle(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy_o[k]) ok = 1'b1;
    end
    if (!ok) fail($sformatf("idle_timeout_dut%0d", k));
  endtask

  // Inputs are scrambled right after acceptance: the latched frame must be unaffected.
  task automatic send(input int k, input logic [1:0] c, input logic [7:0] p);
    wait_idle(k);
    start_i[k] = 1'b1; cmd_i[k] = c; payload_i[k] = p;
    @(negedge clk);
    start_i[k] = 1'b0; cmd_i[k] = ~c; payload_i[k] = ~p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before, acc, run, gaps;
    logic pb, ps;

    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0; cmd_i[k] = 2'b00; payload_i[k] = 8'h00;
    end
    slv_wait[0] = 2;
    slv_wait[1] = 3;

    a_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss_n", {31'd0, ss_n_o[0]}, 32'd1);
    check("rst_mosi", {31'd0, mosi_o[0]}, 32'd0);
    check("rst_busy", {31'd0, busy_o[0]}, 32'd0);
    check("rst_done", {31'd0, done_o[0]}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid_o[0]}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data_o[0]}, 32'd0);
    a_rst_n = 1'b1;

    // RD_WAIT=2: write AC/EE, read it back; a second start mid-frame must be ignored.
    push(0, 10'b0010101100, 1'b0, 8'h00, 12, 15);
    send(0, 2'b00, 8'hAC);
    wait_idle(0);
    push(0, 10'b0111101110, 1'b0, 8'h00, 12, 15);
    send(0, 2'b01, 8'hEE);
    repeat (4) @(negedge clk);
    start_i[0] = 1'b1; cmd_i[0] = 2'b10; payload_i[0] = 8'hFF;
    @(negedge clk);
    start_i[0] = 1'b0;
    wait_idle(0);
    push(0, 10'b1010101100, 1'b0, 8'h00, 12, 15);
    send(0, 2'b10, 8'hAC);
    push(0, 10'b1100000000, 1'b1, 8'hEE, 22, 25);
    send(0, 2'b11, 8'h00);
    push(0, 10'b0000110101, 1'b0, 8'hEE, 12, 15);
    send(0, 2'b00, 8'h35);
    push(0, 10'b0101011010, 1'b0, 8'hEE, 12, 15);
    send(0, 2'b01, 8'h5A);
    push(0, 10'b1000110101, 1'b0, 8'hEE, 12, 15);
    send(0, 2'b10, 8'h35);
    push(0, 10'b1100000000, 1'b1, 8'h5A, 22, 25);
    send(0, 2'b11, 8'h00);
    push(0, 10'b0000000001, 1'b0, 8'h5A, 12, 15);
    send(0, 2'b00, 8'h01);
    wait_idle(0);

    // RD_WAIT=3 against a matching slave, then a slave one cycle early: EE>>1 = 77.
    push(1, 10'b0010101100, 1'b0, 8'h00, 12, 15);
    send(1, 2'b00, 8'hAC);
    push(1, 10'b0111101110, 1'b0, 8'h00, 12, 15);
    send(1, 2'b01, 8'hEE);
    push(1, 10'b1010101100, 1'b0, 8'h00, 12, 15);
    send(1, 2'b10, 8'hAC);
    push(1, 10'b1100000000, 1'b1, 8'hEE, 23, 26);
    send(1, 2'b11, 8'h00);
    wait_idle(1);
    slv_wait[1] = 2;
    push(1, 10'b1100000000, 1'b1, 8'h77, 23, 26);
    send(1, 2'b11, 8'h00);
    wait_idle(1);
    slv_wait[1] = 3;

    // Reset in the middle of SHIFT (frame C3 has MOSI=1 in cycle T0+5).
    send(0, 2'b00, 8'hC3);
    repeat (4) @(negedge clk);
    check("pre_reset_mosi", {31'd0, mosi_o[0]}, 32'd1);
    check("pre_reset_ss_n", {31'd0, ss_n_o[0]}, 32'd0);
    #1 a_rst_n = 1'b0;
    #1;
    check("midrst_ss_n", {31'd0, ss_n_o[0]}, 32'd1);
    check("midrst_mosi", {31'd0, mosi_o[0]}, 32'd0);
    check("midrst_busy", {31'd0, busy_o[0]}, 32'd0);
    check("midrst_rx_data0", {24'd0, rx_data_o[0]}, 32'd0);
    check("midrst_rx_data1", {24'd0, rx_data_o[1]}, 32'd0);
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    done_before = done_seen[0];
    repeat (30) @(negedge clk);
    check("no_done_after_reset", done_seen[0], done_before);

    // Back-to-back: start held high for three frames; the high run between frames is
    // the GAP cycles plus the IDLE cycle in which the next start is accepted.
    for (int i = 0; i < 3; i++) push(0, 10'b0000111100, 1'b0, 8'h00, 12, 15);
    done_before = done_seen[0];
    start_i[0] = 1'b1; cmd_i[0] = 2'b00; payload_i[0] = 8'h3C;
    acc = 0; run = 0; gaps = 0; pb = 1'b0; ps = 1'b1;
    for (int i = 0; i < 200 && acc < 3; i++) begin
      @(negedge clk);
      if (busy_o[0] && !pb) acc++;
      if (ss_n_o[0]) begin
        if (!ps || run > 0) run++;
      end else begin
        if (run > 0) begin
          check("b2b_ss_high_cycles", run, 4);
          gaps++;
        end
        run = 0;
      end
      pb = busy_o[0];
      ps = ss_n_o[0];
    end
    start_i[0] = 1'b0;
    check("b2b_frames_started", acc, 3);
    check("b2b_gaps_seen", gaps, 2);
    wait_idle(0);
    check("b2b_done_pulses", done_seen[0] - done_before, 3);

    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
